// File: rtl/pokey_io_pkg.sv
// Shared types and constants for the POKEY keyboard scanner and pot digitiser.
package pokey_io_pkg;

  typedef enum logic [1:0] {K_IDLE, K_CAND, K_DOWN, K_REL} key_state_t;
  typedef enum logic [1:0] {P_IDLE, P_DUMP, P_COUNT, P_DONE} pot_state_t;

  localparam int unsigned SKCTL_KEYEN   = 1;
  localparam int unsigned SKCTL_FASTPOT = 2;
  localparam int unsigned POT_W         = 8;

endpackage

// File: rtl/pokey_key_debounce.sv
// Keyboard debounce/release FSM: a key must be seen on two consecutive scans
// to be accepted; the first key latched into cmp owns the FSM until released.
module pokey_key_debounce
  import pokey_io_pkg::*;
#(
  parameter int unsigned KEY_BITS = 6
) (
  input  logic                clk179,
  input  logic                rst,
  input  logic                keyen,
  input  logic                step,
  input  logic [KEY_BITS-1:0] ctr,
  input  logic                kr1_n,
  input  logic                kr2_n,
  output logic [KEY_BITS-1:0] kbcode,
  output logic                key_shift,
  output logic                key_irq,
  output logic                key_down
);

  key_state_t          state, state_d;
  logic [KEY_BITS-1:0] cmp, cmp_d, kbcode_d;
  logic                shift_d, irq_d, down_d, at_cmp;

  assign at_cmp = (ctr == cmp);

  always_ff @(posedge clk179) begin
    if (rst) begin
      state     <= K_IDLE;
      cmp       <= '0;
      kbcode    <= '0;
      key_shift <= 1'b0;
      key_irq   <= 1'b0;
      key_down  <= 1'b0;
    end else begin
      state     <= state_d;
      cmp       <= cmp_d;
      kbcode    <= kbcode_d;
      key_shift <= shift_d;
      key_irq   <= irq_d;
      key_down  <= down_d;
    end
  end

  // Next state; nothing outside K_IDLE reacts to a scan position other than cmp.
  always_comb begin
    state_d  = state;
    cmp_d    = cmp;
    kbcode_d = kbcode;
    shift_d  = key_shift;
    irq_d    = 1'b0;
    if (!keyen) begin
      state_d = K_IDLE;
    end else if (step) begin
      case (state)
        K_IDLE: begin
          if (!kr1_n) begin
            cmp_d   = ctr;
            state_d = K_CAND;
          end
        end
        K_CAND: begin
          if (at_cmp) begin
            if (!kr1_n) begin
              kbcode_d = cmp;
              shift_d  = ~kr2_n;
              irq_d    = 1'b1;
              state_d  = K_DOWN;
            end else begin
              state_d = K_IDLE;
            end
          end
        end
        K_DOWN: begin
          if (at_cmp && kr1_n) state_d = K_REL;
        end
        K_REL: begin
          if (at_cmp) state_d = kr1_n ? K_IDLE : K_DOWN;
        end
        default: state_d = K_IDLE;
      endcase
    end
    down_d = (state_d == K_DOWN) || (state_d == K_REL);
  end

endmodule

// File: rtl/pokey_io_scan.sv
// POKEY IO path: keyboard matrix scan counter plus N-channel pot digitiser,
// all on clk179 with slow/fast pot timing selected by clock enable.
module pokey_io_scan
  import pokey_io_pkg::*;
#(
  parameter int unsigned NUM_POTS = 8,
  parameter int unsigned POT_MAX  = 228,
  parameter int unsigned KEY_BITS = 6
) (
  input  logic                  clk179,
  input  logic                  rst,
  input  logic                  tick15,
  input  logic [7:0]            skctl,
  input  logic                  potgo_wr,
  input  logic [NUM_POTS-1:0]   pot_in,
  input  logic                  kr1_n,
  input  logic                  kr2_n,
  output logic [KEY_BITS-1:0]   key_scan_n,
  output logic [KEY_BITS-1:0]   kbcode,
  output logic                  key_shift,
  output logic                  key_irq,
  output logic                  key_down,
  output logic [8*NUM_POTS-1:0] pot_val,
  output logic [NUM_POTS-1:0]   allpot,
  output logic                  pot_dump,
  output logic                  pot_done
);

  localparam logic [POT_W-1:0] POT_TERM = POT_W'(POT_MAX);

  logic [KEY_BITS-1:0] scan_ctr;
  logic                keyen, key_step;
  logic                unused_skctl;

  assign unused_skctl = &{1'b0, skctl[7:3], skctl[0]};
  assign keyen        = skctl[SKCTL_KEYEN];
  assign key_step     = tick15 & keyen;
  assign scan_ctr     = ~key_scan_n;

  // The scan counter is stored inverted so the matrix drive comes straight from a flop.
  always_ff @(posedge clk179) begin
    if (rst || !keyen) key_scan_n <= '1;
    else if (tick15)   key_scan_n <= ~(scan_ctr + KEY_BITS'(1));
  end

  pokey_key_debounce #(.KEY_BITS(KEY_BITS)) u_key (
    .clk179    (clk179),
    .rst       (rst),
    .keyen     (keyen),
    .step      (key_step),
    .ctr       (scan_ctr),
    .kr1_n     (kr1_n),
    .kr2_n     (kr2_n),
    .kbcode    (kbcode),
    .key_shift (key_shift),
    .key_irq   (key_irq),
    .key_down  (key_down)
  );

  pot_state_t           pot_state, pot_state_d;
  logic [POT_W-1:0]     pot_ctr, pot_ctr_d;
  logic                 fast, pot_tick, count_tick, terminal, all_latched;
  logic                 done_d, dump_d;
  logic [NUM_POTS-1:0]  allpot_d;
  logic [8*NUM_POTS-1:0] pot_val_d;

  // Pot speed is frozen at POTGO so a mid-cycle skctl change cannot skew a reading.
  always_ff @(posedge clk179) begin
    if (rst)           fast <= 1'b0;
    else if (potgo_wr) fast <= skctl[SKCTL_FASTPOT];
  end

  assign pot_tick   = fast | tick15;
  assign count_tick = (pot_state == P_COUNT) & pot_tick & ~potgo_wr;
  assign terminal   = count_tick & (pot_ctr == POT_TERM);

  for (genvar i = 0; i < int'(NUM_POTS); i++) begin : g_pot
    logic hit;
    assign hit         = count_tick & allpot[i] & pot_in[i];
    assign allpot_d[i] = potgo_wr | (allpot[i] & ~hit & ~terminal);
    assign pot_val_d[8*i +: 8] = potgo_wr                  ? '0 :
                                 hit                       ? pot_ctr :
                                 (terminal & allpot[i])    ? POT_TERM :
                                 pot_val[8*i +: 8];
  end

  assign all_latched = ~|allpot_d;

  always_ff @(posedge clk179) begin
    if (rst) begin
      pot_state <= P_IDLE;
      pot_ctr   <= '0;
      pot_done  <= 1'b0;
      pot_dump  <= 1'b1;
      allpot    <= '1;
      pot_val   <= '0;
    end else begin
      pot_state <= pot_state_d;
      pot_ctr   <= pot_ctr_d;
      pot_done  <= done_d;
      pot_dump  <= dump_d;
      allpot    <= allpot_d;
      pot_val   <= pot_val_d;
    end
  end

  // POTGO restarts from any state and takes priority over a terminal count.
  always_comb begin
    pot_state_d = pot_state;
    pot_ctr_d   = pot_ctr;
    done_d      = pot_done;
    if (potgo_wr) begin
      pot_state_d = P_DUMP;
      pot_ctr_d   = '0;
      done_d      = 1'b0;
    end else begin
      case (pot_state)
        P_IDLE: pot_state_d = P_IDLE;
        P_DUMP: begin
          if (pot_tick) pot_state_d = P_COUNT;
        end
        P_COUNT: begin
          if (count_tick) begin
            if (terminal || all_latched) begin
              pot_state_d = P_DONE;
              done_d      = 1'b1;
            end else begin
              pot_ctr_d = pot_ctr + POT_W'(1);
            end
          end
        end
        P_DONE: pot_state_d = P_DONE;
        default: pot_state_d = P_IDLE;
      endcase
    end
    dump_d = (pot_state_d == P_IDLE) || (pot_state_d == P_DUMP);
  end

endmodule

// File: tb/tb_pokey_io_scan.sv
// Directed bench for pokey_io_scan: keyboard debounce table, pot digitiser
// table, and hand sequences for restart, mode latch, keyen and reset.
module tb_pokey_io_scan;
  localparam int unsigned NP = 4;
  localparam int unsigned KB = 6;

  logic            clk179 = 1'b0;
  logic            rst, tick15, potgo_wr, kr1_n, kr2_n;
  logic [7:0]      skctl;
  logic [NP-1:0]   pot_in;
  logic [KB-1:0]   key_scan_n, kbcode;
  logic            key_shift, key_irq, key_down, pot_dump, pot_done;
  logic [8*NP-1:0] pot_val;
  logic [NP-1:0]   allpot;

  int total = 0;
  int bad   = 0;
  int irq_cnt = 0;

  logic [KB-1:0] ka, kb, scan;
  logic          ka_en, kb_en, shift_dn;

  pokey_io_scan #(.NUM_POTS(NP), .POT_MAX(228), .KEY_BITS(KB)) dut (
    .clk179(clk179), .rst(rst), .tick15(tick15), .skctl(skctl),
    .potgo_wr(potgo_wr), .pot_in(pot_in), .kr1_n(kr1_n), .kr2_n(kr2_n),
    .key_scan_n(key_scan_n), .kbcode(kbcode), .key_shift(key_shift),
    .key_irq(key_irq), .key_down(key_down), .pot_val(pot_val),
    .allpot(allpot), .pot_dump(pot_dump), .pot_done(pot_done)
  );

  always #5 clk179 = ~clk179;

  // Keyboard matrix model: returns follow the scan lines combinationally.
  assign scan = ~key_scan_n;
  always_comb begin
    kr1_n = ~((ka_en && (scan == ka)) || (kb_en && (scan == kb)));
    kr2_n = ~shift_dn;
  end

  always @(negedge clk179) if (key_irq === 1'b1) irq_cnt++;

  typedef struct {
    logic [KB-1:0] ka; logic ka_en; logic [KB-1:0] kb; logic kb_en; logic sh;
    int scans; logic [KB-1:0] code; logic shv; int irqs; logic down;
  } kvec_t;

  typedef struct {
    logic [NP-1:0][8:0] rise;
    logic [NP-1:0][7:0] val;
    int done_k;
  } pvec_t;

  kvec_t kv[11];
  pvec_t pv[3];

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk179); #1; end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic slow_tick();
    tick15 = 1'b1; cyc(1); tick15 = 1'b0; cyc(2);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_scan_n"}, 64'(key_scan_n), 64'h3F);
    chk({tag, "_kbcode"}, 64'(kbcode), 64'h0);
    chk({tag, "_shift"},  64'(key_shift), 64'h0);
    chk({tag, "_irq"},    64'(key_irq), 64'h0);
    chk({tag, "_down"},   64'(key_down), 64'h0);
    chk({tag, "_potval"}, 64'(pot_val), 64'h0);
    chk({tag, "_allpot"}, 64'(allpot), 64'hF);
    chk({tag, "_dump"},   64'(pot_dump), 64'h1);
    chk({tag, "_done"},   64'(pot_done), 64'h0);
  endtask

  initial begin
    int done_at;

    kv[0]  = '{6'h15, 1'b1, 6'h00, 1'b0, 1'b0, 2, 6'h15, 1'b0, 1, 1'b1};
    kv[1]  = '{6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 2, 6'h15, 1'b0, 1, 1'b0};
    kv[2]  = '{6'h2A, 1'b1, 6'h00, 1'b0, 1'b0, 1, 6'h15, 1'b0, 1, 1'b0};
    kv[3]  = '{6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 1, 6'h15, 1'b0, 1, 1'b0};
    kv[4]  = '{6'h15, 1'b1, 6'h22, 1'b1, 1'b1, 2, 6'h15, 1'b1, 2, 1'b1};
    kv[5]  = '{6'h15, 1'b1, 6'h22, 1'b1, 1'b1, 2, 6'h15, 1'b1, 2, 1'b1};
    kv[6]  = '{6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 2, 6'h15, 1'b1, 2, 1'b0};
    kv[7]  = '{6'h22, 1'b1, 6'h00, 1'b0, 1'b0, 2, 6'h22, 1'b0, 3, 1'b1};
    kv[8]  = '{6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 1, 6'h22, 1'b0, 3, 1'b1};
    kv[9]  = '{6'h22, 1'b1, 6'h00, 1'b0, 1'b0, 1, 6'h22, 1'b0, 3, 1'b1};
    kv[10] = '{6'h00, 1'b0, 6'h00, 1'b0, 1'b0, 2, 6'h22, 1'b0, 3, 1'b0};

    pv[0].rise = {9'h1FF, 9'd227, 9'd0, 9'd50};
    pv[0].val  = {8'd228, 8'd227, 8'd0, 8'd50};
    pv[0].done_k = 229;
    pv[1].rise = {9'd9, 9'd7, 9'd5, 9'd3};
    pv[1].val  = {8'd9, 8'd7, 8'd5, 8'd3};
    pv[1].done_k = 10;
    pv[2].rise = {9'h1FF, 9'd1, 9'h1FF, 9'd228};
    pv[2].val  = {8'd228, 8'd1, 8'd228, 8'd228};
    pv[2].done_k = 229;

    rst = 1'b1; tick15 = 1'b0; skctl = 8'h00; potgo_wr = 1'b0; pot_in = '0;
    ka = '0; kb = '0; ka_en = 1'b0; kb_en = 1'b0; shift_dn = 1'b0;
    cyc(3);
    check_reset("por");
    rst = 1'b0;

    // Scan counter: advances only on tick15 with keyen, held at 0 without keyen.
    skctl = 8'h02; tick15 = 1'b1; cyc(5);
    chk("scan_after5", 64'(key_scan_n), 64'h3A);
    tick15 = 1'b0; cyc(3);
    chk("scan_no_tick", 64'(key_scan_n), 64'h3A);
    skctl = 8'h00; cyc(1);
    chk("scan_keyen_off", 64'(key_scan_n), 64'h3F);

    // Keyboard table, every vector a whole number of 64-step scans.
    skctl = 8'h02; tick15 = 1'b1; irq_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      ka = kv[i].ka; ka_en = kv[i].ka_en; kb = kv[i].kb; kb_en = kv[i].kb_en;
      shift_dn = kv[i].sh;
      cyc(64 * kv[i].scans);
      chk($sformatf("kv%0d_code", i),  64'(kbcode), 64'(kv[i].code));
      chk($sformatf("kv%0d_shift", i), 64'(key_shift), 64'(kv[i].shv));
      chk($sformatf("kv%0d_irqs", i),  64'(irq_cnt), 64'(kv[i].irqs));
      chk($sformatf("kv%0d_down", i),  64'(key_down), 64'(kv[i].down));
    end

    // Dropping keyen forces the FSM idle but keeps the last code.
    ka = 6'h15; ka_en = 1'b1; shift_dn = 1'b0; cyc(128);
    chk("keyen_pre_down", 64'(key_down), 64'h1);
    chk("keyen_pre_code", 64'(kbcode), 64'h15);
    skctl = 8'h00; cyc(1);
    chk("keyen_off_down", 64'(key_down), 64'h0);
    chk("keyen_off_code", 64'(kbcode), 64'h15);
    chk("keyen_off_scan", 64'(key_scan_n), 64'h3F);
    ka_en = 1'b0; tick15 = 1'b0;

    // Pot table in fast mode: k counts pot ticks, evaluating ctr = k-1.
    for (int v = 0; v < 3; v++) begin
      skctl = 8'h04; pot_in = '0; potgo_wr = 1'b1; cyc(1); potgo_wr = 1'b0;
      chk($sformatf("pv%0d_dump_on", v), 64'(pot_dump), 64'h1);
      chk($sformatf("pv%0d_cleared", v), 64'({allpot, pot_done, pot_val}), {27'h0, 4'hF, 1'b0, 32'h0});
      cyc(1);
      chk($sformatf("pv%0d_dump_off", v), 64'(pot_dump), 64'h0);
      done_at = 0;
      for (int k = 1; k <= 300; k++) begin
        for (int j = 0; j < int'(NP); j++) pot_in[j] = ((k - 1) >= int'(pv[v].rise[j]));
        cyc(1);
        if (pot_done === 1'b1) begin done_at = k; break; end
      end
      chk($sformatf("pv%0d_done_at", v), 64'(done_at), 64'(pv[v].done_k));
      chk($sformatf("pv%0d_val", v), 64'(pot_val), 64'(pv[v].val));
      chk($sformatf("pv%0d_allpot", v), 64'(allpot), 64'h0);
      chk($sformatf("pv%0d_dump", v), 64'(pot_dump), 64'h0);
      cyc(3);
      chk($sformatf("pv%0d_hold", v), 64'({pot_done, pot_val}), {31'h0, 1'b1, 32'(pv[v].val)});
    end

    // POTGO coinciding with the terminal count wins.
    pot_in = '0; potgo_wr = 1'b1; cyc(1); potgo_wr = 1'b0; cyc(1); cyc(228);
    chk("race_pre_done", 64'(pot_done), 64'h0);
    potgo_wr = 1'b1; cyc(1); potgo_wr = 1'b0;
    chk("race_done", 64'(pot_done), 64'h0);
    chk("race_dump", 64'(pot_dump), 64'h1);
    chk("race_allpot", 64'(allpot), 64'hF);

    // Slow mode with a mid-cycle fast request that must be ignored.
    skctl = 8'h00; pot_in = '0; potgo_wr = 1'b1; cyc(1); potgo_wr = 1'b0;
    skctl = 8'h04; cyc(2);
    chk("slow_dump_hold", 64'(pot_dump), 64'h1);
    slow_tick();
    chk("slow_dump_off", 64'(pot_dump), 64'h0);
    for (int t = 0; t < 100; t++) begin
      pot_in[1] = (t >= 40);
      slow_tick();
    end
    chk("slow_val1", 64'(pot_val[15:8]), 64'd40);
    chk("slow_allpot", 64'(allpot), 64'hD);
    chk("slow_notdone", 64'(pot_done), 64'h0);
    skctl = 8'h00; pot_in = '0; potgo_wr = 1'b1; tick15 = 1'b1; cyc(1);
    potgo_wr = 1'b0; tick15 = 1'b0;
    chk("restart_val", 64'(pot_val), 64'h0);
    chk("restart_allpot", 64'(allpot), 64'hF);
    chk("restart_dump", 64'(pot_dump), 64'h1);
    cyc(2);
    chk("restart_dump_hold", 64'(pot_dump), 64'h1);
    slow_tick();
    chk("restart_dump_off", 64'(pot_dump), 64'h0);
    repeat (5) slow_tick();
    pot_in[2] = 1'b1; slow_tick();
    chk("restart_val2", 64'(pot_val[23:16]), 64'd5);

    // Reset while the pot is counting and a key is held down.
    skctl = 8'h00; pot_in = '0; cyc(1);
    skctl = 8'h06; tick15 = 1'b1; ka = 6'h15; ka_en = 1'b1;
    potgo_wr = 1'b1; cyc(1); potgo_wr = 1'b0; cyc(127);
    chk("prerst_down", 64'(key_down), 64'h1);
    chk("prerst_counting", 64'({pot_dump, pot_done}), 64'h0);
    rst = 1'b1; cyc(1);
    check_reset("midrst");
    rst = 1'b0; ka_en = 1'b0; tick15 = 1'b0; skctl = 8'h00;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pokey_io_scan.md
Name: pokey_io_scan

Overview:
- Parametrised keyboard-matrix scanner and potentiometer digitiser for the POKEY IO path; everything runs on clk179.
- Adds over the current IO block:
  - N pot channels.
  - Configurable pot count limit.
  - Keyboard debounce/release FSM with key-event strobe and shift sampling.
  - Clock-enable-based slow/fast pot timing (no clock mux or BUFG).
- Feeds the POKEY register file (KBCODE, POTn, ALLPOT, SKSTAT) and IRQ logic.

Parameters:
- NUM_POTS, 8, number of pot channels (1..8).
- POT_MAX, 228, terminal pot count; unlatched channels take this value.
- KEY_BITS, 6, scan counter width (2^KEY_BITS matrix positions).

Ports:
- clk179 in 1 — system clock, 1.79 MHz domain.
- rst in 1 — synchronous, active-high reset.
- tick15 in 1 — one-cycle strobe at ~15 kHz; keyboard scan rate and slow pot rate.
- skctl in 8 — bit1 key scan enable; bit2 fast pot mode.
- potgo_wr in 1 — one-cycle pulse on CPU write to POTGO.
- pot_in in NUM_POTS — comparator outputs, 1 = capacitor threshold reached (pre-synchronised).
- kr1_n in 1 — key return, active low.
- kr2_n in 1 — shift return, active low.
- key_scan_n out KEY_BITS — inverted scan counter.
- kbcode out KEY_BITS — last accepted key code.
- key_shift out 1 — shift state captured with kbcode.
- key_irq out 1 — one-cycle pulse on key accept.
- key_down out 1 — 1 while the FSM is in K_DOWN or K_REL.
- pot_val out 8*NUM_POTS — channel i at bits [8i+7:8i].
- allpot out NUM_POTS — 1 = channel still counting.
- pot_dump out 1 — 1 = discharge capacitors.
- pot_done out 1 — 1 = all channels latched.

Behaviour:
- Reset values: scan counter 0, key_scan_n all ones, kbcode 0, key_shift 0, key_irq 0, key_down 0, pot_val 0, allpot all ones, pot_dump 1, pot_done 0. Both FSMs start in idle.
- Keyboard step: a step occurs on a clk179 edge with tick15=1 and skctl[1]=1.
  - kr1_n/kr2_n are sampled for the current counter value.
  - The counter then increments and wraps 2^KEY_BITS-1 -> 0.
- skctl[1]=0: counter held at 0, key FSM forced to K_IDLE, kbcode/key_shift retained.
- Key FSM (cmp = latched code). All evaluation happens on steps only.
  - K_IDLE: kr1_n=0 -> cmp<=ctr, go K_CAND.
  - K_CAND: at ctr==cmp, kr1_n=0 -> kbcode<=cmp, key_shift<=~kr2_n, key_irq=1 for one cycle, go K_DOWN. At ctr==cmp with kr1_n=1 -> K_IDLE (bounce rejected).
  - K_DOWN: at ctr==cmp, kr1_n=1 -> K_REL.
  - K_REL: at ctr==cmp, kr1_n=1 -> K_IDLE; kr1_n=0 -> K_DOWN (no new irq).
  - In all states except K_IDLE, kr1_n activity at ctr!=cmp is ignored (first key wins).
- Pot tick:
  - Fast mode (skctl[2]=1, sampled at potgo_wr): every clk179 cycle.
  - Slow mode: tick15 cycles.
  - A skctl[2] change mid-cycle is ignored.
- Pot FSM:
  - P_IDLE: pot_dump=1.
  - potgo_wr from any state -> clear pot_val, allpot all ones, pot_done 0, ctr 0, go P_DUMP. Restart mid-count is legal.
  - P_DUMP: pot_dump=1 for exactly one pot tick, then P_COUNT with pot_dump=0.
  - P_COUNT, on each pot tick, per channel i with allpot[i]=1:
    - pot_in[i]=1 -> pot_val[i]<=ctr, allpot[i]<=0.
    - ctr==POT_MAX -> all remaining channels latch POT_MAX, allpot<=0, pot_done<=1, go P_DONE.
    - Otherwise ctr<=ctr+1.
    - All channels latched before POT_MAX -> pot_done<=1, go P_DONE.
  - P_DONE: pot_dump=0, outputs held until the next potgo_wr.
- Simultaneous potgo_wr and terminal count: potgo_wr wins.
- rst asserted mid-operation returns everything to reset values on the next edge.
- ctr is 8 bits; POT_MAX must be <= 255.

Decomposition:
- pokey_io_pkg:
  - key_state_t {K_IDLE, K_CAND, K_DOWN, K_REL}
  - pot_state_t {P_IDLE, P_DUMP, P_COUNT, P_DONE}
  - SKCTL_KEYEN=1, SKCTL_FASTPOT=2.
- Sub-module pokey_key_debounce (key FSM, cmp, kbcode, irq). Pot logic stays in the top module with a per-channel generate loop.

Test Plan:
- kr1_n low only at ctr=0x15 for two full scans -> kbcode=0x15, one key_irq pulse, key_down=1; release for two scans -> key_down=0, no second irq.
- kr1_n low at 0x15 for one scan only -> no irq, kbcode unchanged, FSM back to K_IDLE.
- Key 0x15 held while kr1_n also pulses at 0x22 -> kbcode stays 0x15, single irq; key_shift=1 when kr2_n low at the accept step.
- Fast mode, pot_in[0] rises 50 cycles after P_COUNT entry, pot_in[3] never rises (NUM_POTS=4) -> pot_val[0]=50, pot_val[3]=228, allpot=0, pot_done=1.
- Slow mode: potgo_wr, then potgo_wr again at ctr=100 -> pot_val cleared, pot_dump=1 for one tick15, counting restarts from 0.
- rst during P_COUNT and K_DOWN -> all outputs at reset values next cycle, pot_dump=1.
